// File: rtl/ysyx_22050550_div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and their W-variants, retiring BPC
// quotient bits per cycle, with a fast path for divide-by-zero and signed overflow.
module ysyx_22050550_div_iter #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned BPC  = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic            io_in_signed,
    input  logic            io_in_word,
    input  logic [XLEN-1:0] io_in_dividend,
    input  logic [XLEN-1:0] io_in_divisor,
    input  logic            io_flush,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_out_quot,
    output logic [XLEN-1:0] io_out_rem
);

    localparam int unsigned     CntW     = $clog2(XLEN / BPC);
    localparam bit              WordOk   = (XLEN > 32);
    localparam logic [CntW-1:0] CntFull  = CntW'(XLEN / BPC - 1);
    localparam logic [CntW-1:0] CntWord  = CntW'(32 / BPC - 1);
    localparam logic [XLEN-1:0] Mask32   = XLEN'(32'hFFFF_FFFF);
    localparam logic [XLEN-1:0] MinNeg32 = XLEN'(32'h8000_0000);
    localparam logic [XLEN-1:0] MinNegX  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              word_q;
    logic              quot_neg_q;
    logic              rem_neg_q;
    logic [XLEN-1:0]   dvs_q;
    logic [XLEN-1:0]   dvd_q;
    logic [XLEN-1:0]   pr_q;
    logic [XLEN-1:0]   quot_q;
    logic [XLEN-1:0]   rem_q;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v[31:0];
        return r;
    endfunction

    // Operand decode at accept: magnitudes, signs and fast-path results.
    logic            in_w;
    logic [XLEN-1:0] wmask;
    logic [XLEN-1:0] dvd_w;
    logic [XLEN-1:0] dvs_w;
    logic            dvd_neg;
    logic            dvs_neg;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dvs_mag;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] fast_quot;
    logic [XLEN-1:0] fast_rem;

    always_comb begin
        in_w      = io_in_word & WordOk;
        wmask     = in_w ? Mask32 : '1;
        dvd_w     = io_in_dividend & wmask;
        dvs_w     = io_in_divisor & wmask;
        dvd_neg   = io_in_signed & (in_w ? io_in_dividend[31] : io_in_dividend[XLEN-1]);
        dvs_neg   = io_in_signed & (in_w ? io_in_divisor[31] : io_in_divisor[XLEN-1]);
        dvd_mag   = dvd_neg ? ((-dvd_w) & wmask) : dvd_w;
        dvs_mag   = dvs_neg ? ((-dvs_w) & wmask) : dvs_w;
        div_zero  = (dvs_w == '0);
        ovf       = io_in_signed & (dvd_w == (in_w ? MinNeg32 : MinNegX)) & (dvs_w == wmask);
        fast_quot = div_zero ? wmask : dvd_w;
        fast_rem  = div_zero ? dvd_w : '0;
        if (in_w) begin
            fast_quot = sext32(fast_quot);
            fast_rem  = sext32(fast_rem);
        end
    end

    // BPC restoring steps per cycle; the shifted remainder keeps one extra bit so the
    // compare never truncates.
    logic [XLEN-1:0] pr_n;
    logic [XLEN-1:0] sh_n;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    always_comb begin
        pr_n    = pr_q;
        sh_n    = dvd_q;
        shifted = '0;
        ge      = 1'b0;
        for (int i = 0; i < int'(BPC); i++) begin
            shifted = {pr_n, sh_n[XLEN-1]};
            ge      = (shifted >= {1'b0, dvs_q});
            sh_n    = {sh_n[XLEN-2:0], ge};
            pr_n    = ge ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
        end
        q_fix = quot_neg_q ? -sh_n : sh_n;
        r_fix = rem_neg_q ? -pr_n : pr_n;
        if (word_q) begin
            q_fix = sext32(q_fix);
            r_fix = sext32(r_fix);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            word_q     <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            dvs_q      <= '0;
            dvd_q      <= '0;
            pr_q       <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else if (io_flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (io_in_valid) begin
                        word_q     <= in_w;
                        quot_neg_q <= dvd_neg ^ dvs_neg;
                        rem_neg_q  <= dvd_neg;
                        dvs_q      <= dvs_mag;
                        pr_q       <= '0;
                        // Word operands are left-aligned so the MSB is always the next bit.
                        dvd_q      <= in_w ? (dvd_mag << (XLEN - 32)) : dvd_mag;
                        cnt_q      <= in_w ? CntWord : CntFull;
                        if (div_zero || ovf) begin
                            quot_q  <= fast_quot;
                            rem_q   <= fast_rem;
                            state_q <= StDone;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    pr_q  <= pr_n;
                    dvd_q <= sh_n;
                    if (cnt_q == '0) begin
                        quot_q  <= q_fix;
                        rem_q   <= r_fix;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (io_out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign io_in_ready  = (state_q == StIdle);
    assign io_out_valid = (state_q == StDone);
    assign io_out_quot  = quot_q;
    assign io_out_rem   = rem_q;

endmodule
